// File: rtl/regfile_writeback_arbiter.sv
// rtl/regfile_writeback_arbiter.sv - register-file write-port arbiter with MDU result FIFO and busy scoreboard
//
// Merges single-cycle ALU results and buffered multi-cycle MDU results onto
// the single register-file write port, and tracks which destinations still
// have an MDU result outstanding so decode can stall on them.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   alu_valid/alu_addr/alu_data      ALU result, no backpressure, highest priority
//   mdu_valid/mdu_ready/mdu_addr/... MDU result handshake into the FIFO
//   issue_mark/issue_addr            decode marks an MDU destination busy
//   query_addr1/2, busy1/2           combinational scoreboard lookups
//   write/reg_write_address/write_data  registered write-port outputs
//   fifo_count                       buffered MDU entries
//   sb_error                         sticky protocol-violation flag
module regfile_writeback_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            alu_valid,
    input  logic [ADDR_W-1:0]               alu_addr,
    input  logic [DATA_W-1:0]               alu_data,
    input  logic                            mdu_valid,
    output logic                            mdu_ready,
    input  logic [ADDR_W-1:0]               mdu_addr,
    input  logic [DATA_W-1:0]               mdu_data,
    input  logic                            issue_mark,
    input  logic [ADDR_W-1:0]               issue_addr,
    input  logic [ADDR_W-1:0]               query_addr1,
    input  logic [ADDR_W-1:0]               query_addr2,
    output logic                            busy1,
    output logic                            busy2,
    output logic                            write,
    output logic [ADDR_W-1:0]               reg_write_address,
    output logic [DATA_W-1:0]               write_data,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            sb_error
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam int NREG = 2 ** ADDR_W;

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic              err_q, err_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic              alu_take;
    logic              push;
    logic              pop;
    logic              set_en;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    // Readiness comes from the pre-edge count, so a full FIFO never accepts
    // even when the same edge pops an entry.
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign mdu_ready  = !fifo_full;

    // Writes to r0 are discarded: an ALU one leaves the slot free for the
    // FIFO, an MDU one completes its handshake without being stored.
    assign alu_take = alu_valid && (alu_addr != '0);
    assign push     = mdu_valid && !fifo_full && (mdu_addr != '0);
    assign pop      = !alu_take && !fifo_empty;
    assign set_en   = issue_mark && (issue_addr != '0);

    assign head_addr = fifo_addr_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        write_d  = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        busy_d   = busy_q;
        err_d    = err_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        if (alu_take) begin
            write_d = 1'b1;
            waddr_d = alu_addr;
            wdata_d = alu_data;
        end else if (pop) begin
            write_d  = 1'b1;
            waddr_d  = head_addr;
            wdata_d  = head_data;
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // Clear before set so a new issue to the register being retired
        // this edge keeps it busy.
        if (pop) begin
            busy_d[head_addr] = 1'b0;
        end
        if (set_en) begin
            busy_d[issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;

        if ((set_en && busy_q[issue_addr]) || (alu_take && busy_q[alu_addr])) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            err_q    <= 1'b0;
            write_q  <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            write_q  <= write_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Entry storage needs no reset: only slots covered by count are read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= mdu_addr;
            fifo_data_q[wr_ptr_q] <= mdu_data;
        end
    end

    assign busy1             = busy_q[query_addr1];
    assign busy2             = busy_q[query_addr2];
    assign write             = write_q;
    assign reg_write_address = waddr_q;
    assign write_data        = wdata_q;
    assign fifo_count        = count_q;
    assign sb_error          = err_q;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// tb/tb_regfile_writeback_arbiter.sv - self-checking bench for regfile_writeback_arbiter
module tb_regfile_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_addr = '0;
    logic [31:0] alu_data = '0;
    logic        mdu_valid = 1'b0;
    logic        mdu_ready;
    logic [4:0]  mdu_addr = '0;
    logic [31:0] mdu_data = '0;
    logic        issue_mark = 1'b0;
    logic [4:0]  issue_addr = '0;
    logic [4:0]  query_addr1 = '0;
    logic [4:0]  query_addr2 = '0;
    logic        busy1, busy2;
    logic        write;
    logic [4:0]  reg_write_address;
    logic [31:0] write_data;
    logic [2:0]  fifo_count;
    logic        sb_error;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_writeback_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .alu_valid         (alu_valid),
        .alu_addr          (alu_addr),
        .alu_data          (alu_data),
        .mdu_valid         (mdu_valid),
        .mdu_ready         (mdu_ready),
        .mdu_addr          (mdu_addr),
        .mdu_data          (mdu_data),
        .issue_mark        (issue_mark),
        .issue_addr        (issue_addr),
        .query_addr1       (query_addr1),
        .query_addr2       (query_addr2),
        .busy1             (busy1),
        .busy2             (busy2),
        .write             (write),
        .reg_write_address (reg_write_address),
        .write_data        (write_data),
        .fifo_count        (fifo_count),
        .sb_error          (sb_error)
    );

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        im;
        logic [4:0]  ia;
        logic [4:0]  q1;
        logic [4:0]  q2;
        logic        ew;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic [2:0]  ec;
        logic        er;
        logic        eb1;
        logic        eb2;
        logic        ee;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        alu_valid  = 1'b0;
        alu_addr   = '0;
        alu_data   = '0;
        mdu_valid  = 1'b0;
        mdu_addr   = '0;
        mdu_data   = '0;
        issue_mark = 1'b0;
        issue_addr = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int nxt;
        int got;
        int cyc;
        logic accepted;

        //           av aa  ad            mv ma  md            im ia q1 q2  ew ea  ed            ec er b1 b2 ee
        vecs[0]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 5, 9,  0, 0,  32'h0,        0, 1, 0, 0, 0};
        vecs[1]  = '{1, 5,  32'hDEADBEEF, 0, 0,  32'h0,        0, 0, 5, 9,  1, 5,  32'hDEADBEEF, 0, 1, 0, 0, 0};
        vecs[2]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 5, 9,  0, 5,  32'hDEADBEEF, 0, 1, 0, 0, 0};
        vecs[3]  = '{1, 0,  32'h12345678, 0, 0,  32'h0,        0, 0, 5, 9,  0, 5,  32'hDEADBEEF, 0, 1, 0, 0, 0};
        vecs[4]  = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 9, 9, 3,  0, 5,  32'hDEADBEEF, 0, 1, 1, 0, 0};
        vecs[5]  = '{1, 3,  32'h33,       1, 9,  32'h1234,     0, 0, 9, 3,  1, 3,  32'h33,       1, 1, 1, 0, 0};
        vecs[6]  = '{1, 3,  32'h34,       0, 0,  32'h0,        0, 0, 9, 3,  1, 3,  32'h34,       1, 1, 1, 0, 0};
        vecs[7]  = '{1, 3,  32'h35,       0, 0,  32'h0,        0, 0, 9, 3,  1, 3,  32'h35,       1, 1, 1, 0, 0};
        vecs[8]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 9, 3,  1, 9,  32'h1234,     0, 1, 0, 0, 0};
        vecs[9]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 9, 3,  0, 9,  32'h1234,     0, 1, 0, 0, 0};
        vecs[10] = '{0, 0,  32'h0,        1, 0,  32'hFFFF,     0, 0, 9, 3,  0, 9,  32'h1234,     0, 1, 0, 0, 0};
        vecs[11] = '{1, 3,  32'h36,       1, 7,  32'h77,       0, 0, 7, 9,  1, 3,  32'h36,       1, 1, 0, 0, 0};
        vecs[12] = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 7, 7, 9,  1, 7,  32'h77,       0, 1, 1, 0, 0};
        vecs[13] = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 7, 9,  0, 7,  32'h77,       0, 1, 1, 0, 0};
        vecs[14] = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 7, 7, 9,  0, 7,  32'h77,       0, 1, 1, 0, 1};
        vecs[15] = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 7, 9,  0, 7,  32'h77,       0, 1, 1, 0, 1};

        // Reset state while rst_n is held low.
        #3;
        chk("rst_write", write, 0);
        chk("rst_addr", reg_write_address, 0);
        chk("rst_data", write_data, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", mdu_ready, 1);
        chk("rst_err", sb_error, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            alu_valid   = vecs[i].av;
            alu_addr    = vecs[i].aa;
            alu_data    = vecs[i].ad;
            mdu_valid   = vecs[i].mv;
            mdu_addr    = vecs[i].ma;
            mdu_data    = vecs[i].md;
            issue_mark  = vecs[i].im;
            issue_addr  = vecs[i].ia;
            query_addr1 = vecs[i].q1;
            query_addr2 = vecs[i].q2;
            if (vecs[i].mv) chk($sformatf("v%0d_ready_pre", i), mdu_ready, 1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_write", i), write, vecs[i].ew);
            chk($sformatf("v%0d_addr", i), reg_write_address, vecs[i].ea);
            chk($sformatf("v%0d_data", i), write_data, vecs[i].ed);
            chk($sformatf("v%0d_count", i), fifo_count, vecs[i].ec);
            chk($sformatf("v%0d_ready", i), mdu_ready, vecs[i].er);
            chk($sformatf("v%0d_busy1", i), busy1, vecs[i].eb1);
            chk($sformatf("v%0d_busy2", i), busy2, vecs[i].eb2);
            chk($sformatf("v%0d_err", i), sb_error, vecs[i].ee);
        end

        // Asynchronous reset in the middle of traffic.
        @(negedge clk);
        alu_valid   = 1'b1; alu_addr = 5'd1; alu_data = 32'h11;
        mdu_valid   = 1'b1; mdu_addr = 5'd20; mdu_data = 32'h20;
        issue_mark  = 1'b1; issue_addr = 5'd21;
        query_addr1 = 5'd21; query_addr2 = 5'd20;
        @(posedge clk);
        #1;
        chk("mid_count_pre", fifo_count, 1);
        chk("mid_busy_pre", busy1, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_write", write, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_ready", mdu_ready, 1);
        chk("mid_rst_busy1", busy1, 0);
        chk("mid_rst_busy2", busy2, 0);
        chk("mid_rst_err", sb_error, 0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        // ALU write to a busy register flags an error but still writes.
        @(negedge clk);
        issue_mark = 1'b1; issue_addr = 5'd4; query_addr1 = 5'd4;
        @(posedge clk);
        #1;
        chk("waw_busy", busy1, 1);
        @(negedge clk);
        issue_mark = 1'b0;
        alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h44;
        @(posedge clk);
        #1;
        chk("waw_err", sb_error, 1);
        chk("waw_write", write, 1);
        chk("waw_addr", reg_write_address, 4);
        chk("waw_data", write_data, 32'h44);

        do_reset();

        // Fill the FIFO under continuous ALU traffic; fifth offer must stall.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'(i);
            mdu_valid = 1'b1; mdu_addr = 5'(10 + i); mdu_data = 32'hC0DE0000 + 32'(i);
            @(posedge clk);
            #1;
            chk($sformatf("full%0d_count", i), fifo_count, (i < 4) ? i + 1 : 4);
            chk($sformatf("full%0d_ready", i), mdu_ready, (i < 3) ? 1 : 0);
            chk($sformatf("full%0d_alu_addr", i), reg_write_address, 1);
        end

        // Release the ALU and feed the remaining six with gaps; all ten must
        // emerge in arrival order across pointer wrap.
        nxt = 4;
        got = 0;
        cyc = 0;
        while (got < 10 && cyc < 60) begin
            @(negedge clk);
            alu_valid = 1'b0;
            if (nxt < 10 && (cyc % 2) == 0) begin
                mdu_valid = 1'b1;
                mdu_addr  = 5'(10 + nxt);
                mdu_data  = 32'hC0DE0000 + 32'(nxt);
            end else begin
                mdu_valid = 1'b0;
            end
            accepted = mdu_valid && mdu_ready;
            @(posedge clk);
            if (accepted) nxt++;
            #1;
            if (write) begin
                chk($sformatf("drain%0d_addr", got), reg_write_address, 10 + got);
                chk($sformatf("drain%0d_data", got), write_data, 32'hC0DE0000 + 32'(got));
                got++;
            end
            cyc++;
        end
        chk("drain_total", got, 10);
        chk("drain_count_end", fifo_count, 0);
        chk("drain_ready_end", mdu_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
